pc_next_unit: RTL

Program-counter register and next-PC sequencer for the single-cycle core. Consumes the word-aligned branch offset produced by the shift-left-by-2 stage, plus the branch/jump controls, and holds the PC. Issues instruction-fetch requests with a req/ready handshake to instruction memory. Keeps a retired-instruction counter and flags misaligned targets.

---
 rtl/pc_next_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit
//   Holds the program counter and chooses the next one for the single-cycle core.
//   It fetches through a req/ready handshake to instruction memory, counts
//   retired instructions with a saturating counter, and halts on a misaligned
//   target.
//
// Ports
//   clk            system clock; all state changes on the rising edge
//   rst            synchronous, active-high reset; overrides every other input
//   offset_shifted sign-extended branch immediate, already shifted left by 2
//   branch, zero   a conditional branch is taken when both are set
//   jump           J-type jump; wins over branch
//   jump_index     instruction bits [25:0]
//   stall          holds the PC and the counter for this cycle
//   imem_ready     imem has returned the instruction at pc this cycle
//   pc             current PC (registered)
//   pc_plus4       pc + 4 (combinational)
//   imem_req       fetch request for address pc (only in FETCH)
//   misalign_err   sticky flag: a computed next PC was not word aligned
//   retired_count  instructions accepted since reset, saturating
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | one idle cycle after reset; pc = RESET_VECTOR, no request
// FETCH | requesting pc; advances on imem_ready && !stall
// HALT  | a misaligned target was seen; frozen until rst

module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        offset_shifted,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               stall,
  input  logic               imem_ready,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               imem_req,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [31:0] next_pc;
  logic        accept;

  // Adding 4 wraps mod 2^32, so pc = FFFF_FFFC gives pc_plus4 = 0.
  assign pc_plus4 = pc + 32'd4;

  // Jump has priority over branch. The jump region comes from pc_plus4.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + offset_shifted;
    end
  end

  assign accept = (state == FETCH) && imem_ready && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      imem_req      <= 1'b0;
      misalign_err  <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (accept) begin
            if (next_pc[1:0] != 2'b00) begin
              // A bad target is neither taken nor counted.
              state        <= HALT;
              imem_req     <= 1'b0;
              misalign_err <= 1'b1;
            end else begin
              pc <= next_pc;
              if (retired_count != '1) begin
                retired_count <= retired_count + COUNT_ONE;
              end
            end
          end
        end
        HALT: begin
          imem_req <= 1'b0;
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
